// File: rtl/frame_buffer_pingpong.sv
`default_nettype none
// ============================================================================
//  Module      : frame_buffer_pingpong
//  Description : Two-bank ping-pong frame buffer. The writer fills one bank
//                while the display reads the other; banks swap on the reader's
//                start-of-frame once the writer has signalled a complete frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_buffer_pingpong #(
  parameter int DATA_W = 12,
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wData,
  input  logic              wr_sof,
  input  logic              wr_eof,
  input  logic              oe,
  input  logic [ADDR_W-1:0] rAddr,
  input  logic              rd_sof,
  output logic [DATA_W-1:0] rData,
  output logic              rvalid,
  output logic              frame_ready,
  output logic              wr_blocked,
  output logic [7:0]        drop_cnt
);

  localparam int c_DEPTH = H_RES * V_RES;
  // One extra bit so bank 1 addresses (DEPTH + addr) fit in the index.
  localparam int c_IDX_W = ADDR_W + 1;
  localparam logic [c_IDX_W-1:0] c_DEPTH_IDX = c_IDX_W'(c_DEPTH);

  // Both banks live in one array so a single RAM is inferred.
  logic [DATA_W-1:0] r_mem [0:2*c_DEPTH-1];

  logic              r_wr_bank;
  logic              r_pending;
  logic              r_wr_blocked;
  logic              r_frame_ready;
  logic [7:0]        r_drop_cnt;
  logic              r_rvalid;
  logic              r_rd_en;
  logic [DATA_W-1:0] r_mem_q;

  logic               w_rd_bank;
  logic [c_IDX_W-1:0] w_waddr_x;
  logic [c_IDX_W-1:0] w_raddr_x;
  logic [c_IDX_W-1:0] w_wr_idx;
  logic [c_IDX_W-1:0] w_rd_idx;
  logic               w_wr_en;
  logic               w_rd_en;
  logic               w_swap;

  // The read bank is always the complement of the write bank.
  assign w_rd_bank = ~r_wr_bank;

  assign w_waddr_x = {1'b0, wAddr};
  assign w_raddr_x = {1'b0, rAddr};
  assign w_wr_idx  = r_wr_bank ? (w_waddr_x + c_DEPTH_IDX) : w_waddr_x;
  assign w_rd_idx  = w_rd_bank ? (w_raddr_x + c_DEPTH_IDX) : w_raddr_x;

  // Out-of-range addresses are dropped so they can never alias into the
  // other bank; a blocked writer cannot touch the bank under display.
  assign w_wr_en = we & ~r_wr_blocked & (w_waddr_x < c_DEPTH_IDX);
  assign w_rd_en = oe & r_frame_ready & (w_raddr_x < c_DEPTH_IDX);

  // Swap decision uses the pre-edge pending flag, so a coincident wr_eof
  // only arms the swap for the next rd_sof.
  assign w_swap = rd_sof & r_pending;

  // RAM port: write into the pre-swap write bank, read-first on the read bank.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= wData;
    end
    r_mem_q <= r_mem[w_rd_idx];
  end

  // Bank ownership, frame handshake and drop counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_bank     <= 1'b0;
      r_pending     <= 1'b0;
      r_wr_blocked  <= 1'b0;
      r_frame_ready <= 1'b0;
      r_drop_cnt    <= 8'd0;
    end else begin
      if (w_swap) begin
        r_wr_bank     <= ~r_wr_bank;
        r_pending     <= 1'b0;
        r_wr_blocked  <= 1'b0;
        r_frame_ready <= 1'b1;
      end else if (wr_eof && !r_wr_blocked) begin
        r_pending    <= 1'b1;
        r_wr_blocked <= 1'b1;
      end
      // A new writer frame while locked out is lost, unless the swap on this
      // same edge frees the writer.
      if (wr_sof && r_wr_blocked && !w_swap && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  // Read qualifiers: gate for the RAM output and oe delayed by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_en  <= 1'b0;
      r_rvalid <= 1'b0;
    end else begin
      r_rd_en  <= w_rd_en;
      r_rvalid <= oe;
    end
  end

  assign rData       = r_rd_en ? r_mem_q : '0;
  assign rvalid      = r_rvalid;
  assign frame_ready = r_frame_ready;
  assign wr_blocked  = r_wr_blocked;
  assign drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire

// File: doc/frame_buffer_pingpong.md
FRAME_BUFFER_PINGPONG -- requirements
Module: frame_buffer_pingpong

Interface
REQ-001 SHALL provide parameter DATA_W, default 12, pixel width in bits.
REQ-002 SHALL provide parameter H_RES, default 320, pixels per line.
REQ-003 SHALL provide parameter V_RES, default 240, lines per frame; DEPTH = H_RES*V_RES words per bank.
REQ-004 SHALL provide parameter ADDR_W, default 17, pixel address width; DEPTH <= 2**ADDR_W.
REQ-005 SHALL have the following ports; the block uses one clock, and reset is asynchronous and active-low:
  clk  input  1  sole clock, rising edge
  reset_n  input  1  asynchronous active-low reset
  we  input  1  pixel write strobe
  wAddr  input  ADDR_W  write pixel address
  wData  input  DATA_W  write pixel data
  wr_sof  input  1  writer start-of-frame pulse
  wr_eof  input  1  writer end-of-frame pulse, asserted after the last write
  oe  input  1  read enable
  rAddr  input  ADDR_W  read pixel address
  rd_sof  input  1  reader start-of-frame pulse (display vsync)
  rData  output  DATA_W  read pixel data
  rvalid  output  1  rData qualifier
  frame_ready  output  1  read bank holds a complete frame
  wr_blocked  output  1  writer locked out, awaiting swap
  drop_cnt  output  8  frames dropped while blocked, saturating

Function
REQ-006 SHALL hold two banks of DEPTH x DATA_W, bank b at physical index b*DEPTH + addr, inferable as single-clock block RAM; memory contents are not reset.
REQ-007 SHALL keep 1-bit wr_bank and rd_bank with rd_bank == ~wr_bank at all times.
REQ-008 SHALL write wData to wr_bank at wAddr on a clk edge with we=1, wr_blocked=0, and wAddr < DEPTH; otherwise no write occurs.
REQ-009 SHALL, on wr_eof=1 with wr_blocked=0, set pending=1 and wr_blocked=1 on the next edge.
REQ-010 SHALL ignore wr_eof while wr_blocked=1.
REQ-011 SHALL, on rd_sof=1 with pending=1, swap wr_bank and rd_bank, clear pending and wr_blocked, and set frame_ready=1, all on the same edge.
REQ-012 SHALL leave banks, pending and wr_blocked unchanged on rd_sof=1 with pending=0.
REQ-013 SHALL, on wr_sof=1 while wr_blocked=1 and no swap occurs on that edge, increment drop_cnt, saturating at 255.
REQ-014 SHALL, when wr_eof and rd_sof coincide, evaluate rd_sof against pre-edge pending: no swap on that edge, pending becomes 1, and the swap occurs at the next rd_sof.
REQ-015 SHALL, when rd_sof with pending=1 coincides with we, perform the write into the pre-swap wr_bank.
REQ-016 SHALL, when a swap and wr_sof coincide, not increment drop_cnt.
REQ-017 SHALL register the read with 1-cycle latency: rData = mem[rd_bank, rAddr] when oe=1, frame_ready=1, and rAddr < DEPTH; rData = 0 otherwise.
REQ-018 SHALL use the pre-edge rd_bank for a read issued on a swap edge.
REQ-019 SHALL drive rvalid as oe delayed by one cycle, independent of frame_ready and address range.
REQ-020 SHALL keep frame_ready at 1 once set, until reset.
REQ-021 SHALL, for same-cycle read and write to the same physical word, return the old data (read-first); this is reachable only through a write into rd_bank, which REQ-008 prevents, so no hazard exists.

Reset
REQ-022 SHALL, while reset_n=0, asynchronously force wr_bank=0, rd_bank=1, pending=0, wr_blocked=0, frame_ready=0, drop_cnt=0, rData=0, rvalid=0.
REQ-023 SHALL, on reset asserted mid-frame, discard the pending state; the first rd_sof after reset performs no swap.
REQ-024 SHALL resume normal operation on the first clk edge after reset_n deasserts.

Verification
REQ-025 Defaults: write 0x0..0x12B to addr 0..299, wr_eof, then rd_sof -> frame_ready=1; reading addr 5 returns 0x005 one cycle later with rvalid=1.
REQ-026 Before any swap: oe=1, rAddr=5 -> rData=0x000, rvalid=1.
REQ-027 Blocking: after wr_eof and no rd_sof, we=1 to addr 0 with 0xFFF -> ignored; 300 wr_sof pulses -> drop_cnt=255; rd_sof -> wr_blocked=0.
REQ-028 Coincidence: wr_eof and rd_sof on the same edge -> no swap and pending=1; next rd_sof swaps and frame_ready=1.
REQ-029 Range: we to addr 76800 -> no write in either bank; oe with rAddr=76800 -> rData=0.
REQ-030 Reset mid-operation: reset_n=0 while wr_blocked=1 and drop_cnt=3 -> all outputs 0 immediately, without a clk edge; then rd_sof -> no swap, frame_ready stays 0.
